// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-ported SRAM wrapper between two requesters.
// Optional macro SRAM_ARBITER_RDATA_REG_EN registers per-port read data (latency 2).
module sram_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       p0_req,
  input  logic                       p0_lock,
  input  logic                       p0_we,
  input  logic [WIDTH/8-1:0]         p0_be,
  input  logic [$clog2(DEPTH)-1:0]   p0_addr,
  input  logic [WIDTH-1:0]           p0_wdata,
  input  logic                       p1_req,
  input  logic                       p1_lock,
  input  logic                       p1_we,
  input  logic [WIDTH/8-1:0]         p1_be,
  input  logic [$clog2(DEPTH)-1:0]   p1_addr,
  input  logic [WIDTH-1:0]           p1_wdata,
  output logic                       p0_gnt,
  output logic                       p1_gnt,
  output logic                       p0_rvalid,
  output logic                       p1_rvalid,
  output logic [WIDTH-1:0]           p0_rdata,
  output logic [WIDTH-1:0]           p1_rdata,
  output logic                       sram_cs_n,
  output logic                       sram_we_n,
  output logic [WIDTH/8-1:0]         sram_be_n,
  output logic [$clog2(DEPTH)-1:0]   sram_addr,
  output logic [WIDTH-1:0]           sram_wdata,
  input  logic [WIDTH-1:0]           sram_rdata
);

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  logic        r_rr_last;
  owner_e      r_lock_owner;
  logic [7:0]  r_lock_cnt;
  owner_e      r_rd_owner;

  logic        w_hold0;
  logic        w_hold1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_gnt_any;
  logic        w_gnt_we;
  logic        w_gnt_lock;
  owner_e      w_gnt_owner;

  // Lock owner keeps the bus until it hits MAX_LOCK while the other port waits;
  // the forced handover then falls through to round-robin, which picks the waiter.
  always_comb begin
    w_hold0 = (r_lock_owner == OWN_P0) && p0_req && ((r_lock_cnt < LOCK_MAX) || !p1_req);
    w_hold1 = (r_lock_owner == OWN_P1) && p1_req && ((r_lock_cnt < LOCK_MAX) || !p0_req);
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    if (w_hold0) begin
      w_gnt0 = 1'b1;
    end else if (w_hold1) begin
      w_gnt1 = 1'b1;
    end else if (p0_req && p1_req) begin
      w_gnt0 = r_rr_last;
      w_gnt1 = !r_rr_last;
    end else begin
      w_gnt0 = p0_req;
      w_gnt1 = p1_req;
    end
  end

  always_comb begin
    w_gnt_any   = w_gnt0 | w_gnt1;
    w_gnt_we    = w_gnt1 ? p1_we   : (w_gnt0 & p0_we);
    w_gnt_lock  = w_gnt1 ? p1_lock : (w_gnt0 & p0_lock);
    w_gnt_owner = w_gnt1 ? OWN_P1  : (w_gnt0 ? OWN_P0 : OWN_NONE);
  end

  assign p0_gnt     = w_gnt0;
  assign p1_gnt     = w_gnt1;
  assign sram_cs_n  = !w_gnt_any;
  assign sram_we_n  = !w_gnt_we;
  assign sram_be_n  = w_gnt1 ? ~p1_be : (w_gnt0 ? ~p0_be : '1);
  assign sram_addr  = w_gnt1 ? p1_addr  : p0_addr;
  assign sram_wdata = w_gnt1 ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last    <= 1'b1;
      r_lock_owner <= OWN_NONE;
      r_lock_cnt   <= '0;
      r_rd_owner   <= OWN_NONE;
    end else if (w_gnt_any) begin
      r_rr_last  <= w_gnt1;
      r_rd_owner <= w_gnt_we ? OWN_NONE : w_gnt_owner;
      if (w_gnt_lock) begin
        r_lock_owner <= w_gnt_owner;
        // Saturate so an uncontended owner cannot wrap the count back below MAX_LOCK.
        if (r_lock_owner == w_gnt_owner)
          r_lock_cnt <= (r_lock_cnt == 8'hFF) ? r_lock_cnt : r_lock_cnt + 8'd1;
        else
          r_lock_cnt <= 8'd1;
      end else begin
        r_lock_owner <= OWN_NONE;
        r_lock_cnt   <= '0;
      end
    end else begin
      // No grant means nobody requested, so any lock owner has dropped its request.
      r_lock_owner <= OWN_NONE;
      r_lock_cnt   <= '0;
      r_rd_owner   <= OWN_NONE;
    end
  end

`ifdef SRAM_ARBITER_RDATA_REG_EN
  logic             r_p0_rvalid;
  logic             r_p1_rvalid;
  logic [WIDTH-1:0] r_p0_rdata;
  logic [WIDTH-1:0] r_p1_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_p0_rvalid <= (r_rd_owner == OWN_P0);
      r_p1_rvalid <= (r_rd_owner == OWN_P1);
      if (r_rd_owner == OWN_P0) r_p0_rdata <= sram_rdata;
      if (r_rd_owner == OWN_P1) r_p1_rdata <= sram_rdata;
    end
  end

  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
`else
  assign p0_rvalid = (r_rd_owner == OWN_P0);
  assign p1_rvalid = (r_rd_owner == OWN_P1);
  assign p0_rdata  = sram_rdata;
  assign p1_rdata  = sram_rdata;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed stimulus pushes expected read responses,
// a negedge monitor pops them on rvalid and checks data and arrival cycle.
module tb_sram_arbiter;

`ifdef SRAM_ARBITER_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req, p0_lock, p0_we, p1_req, p1_lock, p1_we;
  logic [3:0]  p0_be, p1_be;
  logic [8:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        sram_cs_n, sram_we_n;
  logic [3:0]  sram_be_n;
  logic [8:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] mem [512];

  sram_arbiter #(.WIDTH(32), .DEPTH(512), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_be(p0_be),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_be(p1_be),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM wrapper model: byte-masked write at the grant edge, registered read data.
  always @(posedge clk) begin
    if (!sram_cs_n) begin
      if (!sram_we_n) begin
        for (int unsigned b = 0; b < 4; b++)
          if (!sram_be_n[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_gnt(input string nm, input logic e0, input logic e1);
    chk({nm, "_p0_gnt"}, {31'd0, p0_gnt}, {31'd0, e0});
    chk({nm, "_p1_gnt"}, {31'd0, p1_gnt}, {31'd0, e1});
  endtask

  task automatic set_p0(input logic req, input logic lock, input logic we,
                        input logic [3:0] be, input logic [8:0] addr, input logic [31:0] wd);
    p0_req = req; p0_lock = lock; p0_we = we; p0_be = be; p0_addr = addr; p0_wdata = wd;
  endtask

  task automatic set_p1(input logic req, input logic lock, input logic we,
                        input logic [3:0] be, input logic [8:0] addr, input logic [31:0] wd);
    p1_req = req; p1_lock = lock; p1_we = we; p1_be = be; p1_addr = addr; p1_wdata = wd;
  endtask

  task automatic push0(input logic [31:0] d);
    exp_t e;
    e.data = d; e.due = cyc + LAT;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [31:0] d);
    exp_t e;
    e.data = d; e.due = cyc + LAT;
    q1.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: runs every negedge, independent of the stimulus.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (p0_rvalid) begin
        if (q0.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL p0_rvalid_spurious: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q0.pop_front();
          chk("p0_rdata", p0_rdata, e.data);
          chk("p0_rvalid_cycle", cyc, e.due);
        end
      end else if (q0.size() != 0 && q0[0].due <= cyc) begin
        n_checks++; n_err++;
        $display("FAIL p0_rvalid_missing: got 0 expected 1 (due cycle %0d)", q0[0].due);
        void'(q0.pop_front());
      end
      if (p1_rvalid) begin
        if (q1.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL p1_rvalid_spurious: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          chk("p1_rdata", p1_rdata, e.data);
          chk("p1_rvalid_cycle", cyc, e.due);
        end
      end else if (q1.size() != 0 && q1[0].due <= cyc) begin
        n_checks++; n_err++;
        $display("FAIL p1_rvalid_missing: got 0 expected 1 (due cycle %0d)", q1[0].due);
        void'(q1.pop_front());
      end
    end
  end

  initial begin
    int n0;
    int n1;
    for (int unsigned i = 0; i < 512; i++) mem[i] = 32'hA500_0000 | i;
    sram_rdata = '0;
    set_p0(0, 0, 0, 4'h0, 9'h0, 32'h0);
    set_p1(0, 0, 0, 4'h0, 9'h0, 32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("rst_cs_n", {31'd0, sram_cs_n}, 32'd1);
`ifdef SRAM_ARBITER_RDATA_REG_EN
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
`endif
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single p0 read of 0x010
    set_p0(1, 0, 0, 4'hF, 9'h010, 32'h0);
    @(negedge clk);
    chk_gnt("t1", 1, 0);
    chk("t1_cs_n", {31'd0, sram_cs_n}, 32'd0);
    chk("t1_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("t1_addr", {23'd0, sram_addr}, 32'h010);
    push0(32'hA500_0010);
    next_cycle();
    set_p0(0, 0, 0, 4'h0, 9'h0, 32'h0);
    repeat (3) next_cycle();

    // p1 partial write to 0x1FF; leaves rr_last = 1 for the alternation test
    set_p1(1, 0, 1, 4'b0011, 9'h1FF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk_gnt("t3w", 0, 1);
    chk("t3w_we_n", {31'd0, sram_we_n}, 32'd0);
    chk("t3w_be_n", {28'd0, sram_be_n}, 32'hC);
    chk("t3w_addr", {23'd0, sram_addr}, 32'h1FF);
    chk("t3w_wdata", sram_wdata, 32'hDEAD_BEEF);
    next_cycle();
    set_p1(0, 0, 0, 4'h0, 9'h0, 32'h0);
    next_cycle();

    // Both ports reading every cycle: p0, p1, p0, p1 with no idle SRAM cycle
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 4; k++) begin
      set_p0(1, 0, 0, 4'hF, 9'(32'h020 + n0), 32'h0);
      set_p1(1, 0, 0, 4'hF, 9'(32'h040 + n1), 32'h0);
      @(negedge clk);
      chk("t2_cs_n", {31'd0, sram_cs_n}, 32'd0);
      if (k % 2 == 0) begin
        chk_gnt("t2", 1, 0);
        push0(32'hA500_0020 + 32'(n0));
        n0++;
      end else begin
        chk_gnt("t2", 0, 1);
        push1(32'hA500_0040 + 32'(n1));
        n1++;
      end
      next_cycle();
    end
    set_p0(0, 0, 0, 4'h0, 9'h0, 32'h0);
    set_p1(0, 0, 0, 4'h0, 9'h0, 32'h0);
    next_cycle();

    // p0 reads back 0x1FF: low half written, upper bytes untouched
    set_p0(1, 0, 0, 4'hF, 9'h1FF, 32'h0);
    @(negedge clk);
    chk_gnt("t3r", 1, 0);
    push0(32'hA500_BEEF);
    next_cycle();
    set_p0(0, 0, 0, 4'h0, 9'h0, 32'h0);
    repeat (3) next_cycle();

    // Locked burst: p0 alone first, then p1 contends; handover on the 9th grant
    for (int k = 0; k < 9; k++) begin
      set_p0(1, 1, 0, 4'hF, 9'(32'h060 + k), 32'h0);
      if (k > 0) set_p1(1, 0, 0, 4'hF, 9'h080, 32'h0);
      @(negedge clk);
      if (k < 8) begin
        chk_gnt("t4_lock", 1, 0);
        push0(32'hA500_0060 + 32'(k));
      end else begin
        chk_gnt("t4_handover", 0, 1);
        push1(32'hA500_0080);
      end
      next_cycle();
    end
    set_p0(0, 0, 0, 4'h0, 9'h0, 32'h0);
    set_p1(0, 0, 0, 4'h0, 9'h0, 32'h0);
    repeat (4) next_cycle();

    // Reset between a p0 read grant and its data phase drops the response
    set_p0(1, 0, 0, 4'hF, 9'h030, 32'h0);
    @(negedge clk);
    chk_gnt("t5_pre", 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_p0(0, 0, 0, 4'h0, 9'h0, 32'h0);
    @(negedge clk);
    chk("t5_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    chk("t5_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    set_p0(1, 0, 0, 4'hF, 9'h031, 32'h0);
    set_p1(1, 0, 0, 4'hF, 9'h041, 32'h0);
    @(negedge clk);
    chk_gnt("t5_post_rr", 1, 0);
    push0(32'hA500_0031);
    next_cycle();
    set_p0(0, 0, 0, 4'h0, 9'h0, 32'h0);
    @(negedge clk);
    chk_gnt("t5_post_p1", 0, 1);
    push1(32'hA500_0041);
    next_cycle();
    set_p1(0, 0, 0, 4'h0, 9'h0, 32'h0);
    repeat (3) next_cycle();

    // p1 read of 0x020, then a p1 write must not disturb the returned data
    set_p1(1, 0, 0, 4'hF, 9'h020, 32'h0);
    @(negedge clk);
    chk_gnt("t6_rd", 0, 1);
    push1(32'hA500_0020);
    next_cycle();
    set_p1(0, 0, 0, 4'h0, 9'h0, 32'h0);
    repeat (3) next_cycle();
    set_p1(1, 0, 1, 4'hF, 9'h021, 32'h1234_5678);
    @(negedge clk);
    chk_gnt("t6_wr", 0, 1);
    next_cycle();
    set_p1(0, 0, 0, 4'h0, 9'h0, 32'h0);
    repeat (2) next_cycle();
`ifdef SRAM_ARBITER_RDATA_REG_EN
    @(negedge clk);
    chk("t6_p1_rdata_hold", p1_rdata, 32'hA500_0020);
`endif
    chk("t6_mem_written", mem[9'h021], 32'h1234_5678);

    repeat (4) next_cycle();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
